// File: rtl/branch_pkg.sv
// Shared constants and types for the branch/PC resolution stage.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from funct3 and the comparator flags.
// Kept separate so pipelined variants can reuse it unchanged.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       equal_i,
    input  logic       lesser_s_i,
    input  logic       lesser_u_i,
    output logic       cond_o
);

    // Select the comparator flag (or its complement) named by funct3.
    // The reserved encodings 010/011 fall into the default and never take.
    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = equal_i;
            F3_BNE:  cond_o = ~equal_i;
            F3_BLT:  cond_o = lesser_s_i;
            F3_BGE:  cond_o = ~lesser_s_i;
            F3_BLTU: cond_o = lesser_u_i;
            F3_BGEU: cond_o = ~lesser_u_i;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register, branch/jump target resolution, misaligned-target trap and
// taken-transfer counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | resolving instructions; PC advances on en_i
// TRAP  | misaligned target captured; waiting for trap_ack_i
module branch_pc_unit
    import branch_pkg::*;
#(
    parameter int                 nb_bits  = 32,
    parameter logic [nb_bits-1:0] reset_pc = 32'h0000_0000,
    parameter logic [nb_bits-1:0] trap_vec = 32'h0000_0100
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               branch_i,
    input  logic               jal_i,
    input  logic               jalr_i,
    input  logic [2:0]         funct3_i,
    input  logic               equal_i,
    input  logic               lesser_s_i,
    input  logic               lesser_u_i,
    input  logic [nb_bits-1:0] rs1_i,
    input  logic [nb_bits-1:0] imm_i,
    input  logic               trap_ack_i,
    output logic [nb_bits-1:0] pc_o,
    output logic [nb_bits-1:0] pc_plus4_o,
    output logic               taken_o,
    output logic               trap_o,
    output logic [nb_bits-1:0] bad_target_o,
    output logic [31:0]        taken_count_o
);

    localparam logic [nb_bits-1:0] FOUR      = nb_bits'(4);
    localparam logic [nb_bits-1:0] CLR_BIT0  = ~nb_bits'(1);

    state_t             state_q, state_d;
    logic [nb_bits-1:0] pc_q, pc_d;
    logic               trap_q, trap_d;
    logic [nb_bits-1:0] bad_target_q, bad_target_d;
    logic [31:0]        taken_count_q, taken_count_d;

    logic               cond;
    logic [nb_bits-1:0] pc_rel_target;
    logic [nb_bits-1:0] jalr_target;
    logic [nb_bits-1:0] target;
    logic               misaligned;

    branch_cond u_branch_cond (
        .funct3_i   (funct3_i),
        .equal_i    (equal_i),
        .lesser_s_i (lesser_s_i),
        .lesser_u_i (lesser_u_i),
        .cond_o     (cond)
    );

    // Target adders; JALR wins over the PC-relative forms when both are set.
    always_comb begin
        pc_rel_target = pc_q + imm_i;
        jalr_target   = (rs1_i + imm_i) & CLR_BIT0;
        target        = jalr_i ? jalr_target : pc_rel_target;
        pc_plus4_o    = pc_q + FOUR;
        taken_o       = (jal_i | jalr_i | (branch_i & cond)) & (state_q == RUN);
        misaligned    = taken_o & (target[1:0] != 2'b00);
    end

    // Next-state, PC, trap capture and counter update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        trap_d        = trap_q;
        bad_target_d  = bad_target_q;
        taken_count_d = taken_count_q;
        case (state_q)
            RUN: begin
                if (en_i) begin
                    if (misaligned) begin
                        bad_target_d = target;
                        trap_d       = 1'b1;
                        state_d      = TRAP;
                    end else if (taken_o) begin
                        pc_d          = target;
                        taken_count_d = taken_count_q + 32'd1;
                    end else begin
                        pc_d = pc_plus4_o;
                    end
                end
            end
            TRAP: begin
                if (trap_ack_i) begin
                    pc_d    = trap_vec;
                    trap_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= RUN;
            pc_q          <= reset_pc;
            trap_q        <= 1'b0;
            bad_target_q  <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            trap_q        <= trap_d;
            bad_target_q  <= bad_target_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign pc_o          = pc_q;
    assign trap_o        = trap_q;
    assign bad_target_o  = bad_target_q;
    assign taken_count_o = taken_count_q;

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter register and branch/jump resolution stage for the RV32I monocycle core. It consumes the flags produced by the signed and unsigned comparators on rs1/rs2, together with decode controls, and decides whether a conditional branch is taken. It computes and registers the next PC, and traps on misaligned control-flow targets. It also keeps a taken-transfer counter for performance monitoring.

## Interface
Parameters:
- nb_bits, 32, datapath/PC width
- reset_pc, 32'h0000_0000, PC value after reset
- trap_vec, 32'h0000_0100, PC loaded when a trap is acknowledged

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- en_i  in  1  instruction retire enable; PC advances only when 1
- branch_i  in  1  conditional branch instruction
- jal_i  in  1  JAL instruction
- jalr_i  in  1  JALR instruction
- funct3_i  in  3  branch condition select
- equal_i  in  1  rs1 == rs2
- lesser_s_i  in  1  rs1 < rs2, signed
- lesser_u_i  in  1  rs1 < rs2, unsigned
- rs1_i  in  nb_bits  rs1 operand, used by JALR
- imm_i  in  nb_bits  sign-extended immediate
- trap_ack_i  in  1  trap handler acknowledge
- pc_o  out  nb_bits  current PC, registered
- pc_plus4_o  out  nb_bits  pc_o+4, the link value; combinational
- taken_o  out  1  control transfer taken this cycle; combinational
- trap_o  out  1  misaligned-target trap pending; registered
- bad_target_o  out  nb_bits  captured offending target; registered
- taken_count_o  out  32  count of committed taken transfers; registered

## Operation
- Branch conditions, selected by funct3:
  - 000 BEQ: equal_i
  - 001 BNE: ~equal_i
  - 100 BLT: lesser_s_i
  - 101 BGE: ~lesser_s_i
  - 110 BLTU: lesser_u_i
  - 111 BGEU: ~lesser_u_i
  - 010 and 011: never taken; no trap.
- Priority when several controls are high: jalr_i > jal_i > branch_i.
- Targets, all arithmetic modulo 2^nb_bits with no overflow flag:
  - branch and JAL: pc_o + imm_i
  - JALR: (rs1_i + imm_i) with bit 0 forced to 0
- taken_o = (jal_i | jalr_i | (branch_i & cond)) & state==RUN.
- Misaligned: taken_o=1 and target[1:0]≠00. Not-taken branches never trap.
- FSM states: RUN, TRAP. Reset state is RUN.
- RUN, en_i=0: all state holds.
- RUN, en_i=1, taken, aligned: pc_o←target; taken_count_o increments, wrapping at 2^32.
- RUN, en_i=1, not taken: pc_o←pc_o+4.
- RUN, en_i=1, taken, misaligned: pc_o holds; bad_target_o←target; trap_o←1; state←TRAP; counter unchanged.
- TRAP: en_i and all control inputs are ignored; taken_o=0.
- TRAP, trap_ack_i=1: pc_o←trap_vec; trap_o←0; state←RUN. bad_target_o keeps its value until the next trap.
- trap_ack_i in RUN is ignored.

## Timing
- Reset values (rst_n_i=0 at an edge):
  - pc_o=reset_pc
  - trap_o=0
  - bad_target_o=0
  - taken_count_o=0
  - state=RUN
- Reset has priority over every other input. Reset asserted while in TRAP clears the trap in the same edge.
- taken_o and pc_plus4_o are combinational, valid in the same cycle as their inputs.
- pc_o, trap_o, bad_target_o and taken_count_o update 1 cycle after the qualifying edge.
- trap_o rises on the edge that samples the misaligned transfer. It stays high for a minimum of 1 cycle and until the edge where trap_ack_i=1 is sampled.
- After that edge, pc_o=trap_vec and a new instruction may be resolved in the following cycle.
- pc_o+4 wraps: 32'hFFFF_FFFC → 32'h0000_0000.

## Structure
- Package branch_pkg:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - state typedef: enum logic {RUN, TRAP}
- Sub-module branch_cond: combinational funct3 and flags → cond. It is reused by future pipelined variants.
- The top module holds the target adders, the FSM, the PC register and the counter.

## Test plan
- Reset, then en_i=1 with no controls for 3 cycles → pc_o goes 0→4→8→C; taken_o=0; taken_count_o=0.
- pc_o=0x10, branch_i=1, funct3=100, lesser_s_i=1, imm=-8 → taken_o=1; next pc_o=0x08; taken_count_o=1.
- Repeat the previous case with funct3=110, lesser_u_i=0 → not taken; next pc_o=0x14.
- Repeat with funct3=010 → never taken; next pc_o=pc_o+4.
- jalr_i=1, rs1=0x103, imm=0 → target 0x102, misaligned:
  - trap_o=1; bad_target_o=0x102; pc_o holds
  - en_i pulses in TRAP are ignored
  - trap_ack_i → pc_o=0x100; trap_o=0; count unchanged.
- jal_i=1 and branch_i=1 together, imm=0x20, pc=0x40 → pc_o=0x60 (JAL wins).
- Assert rst_n_i=0 while in TRAP → pc_o=reset_pc; trap_o=0; counter=0.
- pc_o=0xFFFF_FFFC with no controls → pc_o wraps to 0.
